mem_bus_arbiter: RTL and testbench

- Shares one memory-side bus between two requesters: the instruction-cache miss port (I) and the data-cache miss/uncached port (D).
- Sits between the processor's cache controllers and the DRAM/peripheral bus.
- Serialises requests, arbitrates round-robin, and returns a per-requester wait and read data using the single-pulse-enable / delayed-wait bus protocol.

---
 rtl/mem_bus_arbiter.sv | 91 +++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-pulse-enable memory bus between the I and D cache miss ports.
// Default build arbitrates round-robin; define MEM_ARB_DPRIO_EN to let D always win simultaneous requests.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic [AW-1:0]   i_address,
    output logic            i_wait,
    input  logic            d_en,
    input  logic            d_wren,
    input  logic [AW-1:0]   d_address,
    input  logic [DW-1:0]   d_writedata,
    input  logic [DW/8-1:0] d_byteen,
    output logic [DW-1:0]   d_readdata,
    output logic            d_wait,
    output logic            mem_en,
    output logic            mem_wren,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_writedata,
    output logic [DW/8-1:0] mem_byteen,
    input  logic [DW-1:0]   mem_readdata,
    input  logic            mem_wait,
    output logic            mem_grant_d
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic take, pick_d, grant_d, cmd_wren;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_writedata, rd_q;
    logic [DW/8-1:0] cmd_byteen;
    assign take = (state == IDLE) & (i_en | d_en);
`ifdef MEM_ARB_DPRIO_EN
    assign pick_d = d_en;
`else
    logic last_d;
    assign pick_d = d_en & (~i_en | ~last_d);
    // Remember the last winner so a tie goes to the other requester.
    always_ff @(posedge clk) begin
        if (reset) last_d <= 1'b0;
        else if (take) last_d <= pick_d;
    end
`endif
    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // Next state: one ISSUE cycle, then wait for the memory to drop mem_wait.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = take ? ISSUE : IDLE;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = mem_wait ? WAIT : DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end
    // Latch the winning request; I fetches are full-word reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_d       <= 1'b0;
            cmd_wren      <= 1'b0;
            cmd_address   <= '0;
            cmd_writedata <= '0;
            cmd_byteen    <= '0;
        end else if (take) begin
            grant_d       <= pick_d;
            cmd_wren      <= pick_d & d_wren;
            cmd_address   <= pick_d ? d_address : i_address;
            cmd_writedata <= pick_d ? d_writedata : '0;
            cmd_byteen    <= pick_d ? d_byteen : '1;
        end
    end
    // Capture read data only for D reads as the memory completes.
    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else if (state == WAIT && !mem_wait && grant_d && !cmd_wren) rd_q <= mem_readdata;
    end
    assign mem_en        = state == ISSUE;
    assign mem_wren      = cmd_wren;
    assign mem_address   = cmd_address;
    assign mem_writedata = cmd_writedata;
    assign mem_byteen    = cmd_byteen;
    assign mem_grant_d   = grant_d;
    assign d_readdata    = rd_q;
    assign i_wait        = i_en & ~(state == DONE & ~grant_d);
    assign d_wait        = d_en & ~(state == DONE & grant_d);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors, corner sequences and a randomized transaction-level model.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    logic clk = 1'b0;
    logic reset, i_en, i_wait, d_en, d_wren, d_wait, mem_en, mem_wren, mem_wait, mem_grant_d;
    logic [AW-1:0] i_address, d_address, mem_address;
    logic [DW-1:0] d_writedata, d_readdata, mem_writedata, mem_readdata;
    logic [BW-1:0] d_byteen, mem_byteen;
    int checks = 0;
    int errors = 0;
    int unsigned mem_lat = 0;
    int unsigned rem = 0;
    typedef struct {
        logic          use_d;
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            lat;
        logic [DW-1:0] rdata;
        logic          exp_wren;
        logic [BW-1:0] exp_be;
        logic [DW-1:0] exp_rd;
        int            exp_lat;
    } vec_t;
    vec_t vecs [6];
    logic exp_order [4];
    mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .i_en(i_en), .i_address(i_address), .i_wait(i_wait),
        .d_en(d_en), .d_wren(d_wren), .d_address(d_address), .d_writedata(d_writedata),
        .d_byteen(d_byteen), .d_readdata(d_readdata), .d_wait(d_wait),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_byteen(mem_byteen),
        .mem_readdata(mem_readdata), .mem_wait(mem_wait), .mem_grant_d(mem_grant_d)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Start of a cycle; the memory model raises mem_wait for mem_lat cycles after each mem_en.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_en) begin
            rem = mem_lat;
            mem_wait = 1'b0;
        end else begin
            mem_wait = rem > 0;
            if (rem > 0) rem--;
        end
    endtask
    task automatic look();
        @(negedge clk);
    endtask
    task automatic do_reset();
        tick();
        reset = 1'b1; i_en = 1'b0; d_en = 1'b0; d_wren = 1'b0; rem = 0; mem_wait = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask
    task automatic run_vec(input vec_t v, input string tag);
        int pulses;
        bit seen;
        pulses = 0;
        seen = 1'b0;
        tick();
        mem_lat = v.lat;
        mem_readdata = v.rdata;
        if (v.use_d) begin
            d_en = 1'b1; d_wren = v.wren; d_address = v.addr; d_writedata = v.wdata; d_byteen = v.be;
        end else begin
            i_en = 1'b1; i_address = v.addr;
        end
        for (int n = 1; n <= 20 && !seen; n++) begin
            tick();
            look();
            if (mem_en) begin
                pulses++;
                chk({tag, "_addr"}, 64'(mem_address), 64'(v.addr));
                chk({tag, "_wren"}, 64'(mem_wren), 64'(v.exp_wren));
                chk({tag, "_byteen"}, 64'(mem_byteen), 64'(v.exp_be));
                chk({tag, "_grant"}, 64'(mem_grant_d), 64'(v.use_d));
                if (v.use_d) chk({tag, "_wdata"}, 64'(mem_writedata), 64'(v.wdata));
            end
            if (!(v.use_d ? d_wait : i_wait)) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
                chk({tag, "_rdata"}, 64'(d_readdata), 64'(v.exp_rd));
                chk({tag, "_other_wait"}, 64'(v.use_d ? i_wait : d_wait), 64'(0));
            end
        end
        i_en = 1'b0; d_en = 1'b0; d_wren = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'(1));
        chk({tag, "_pulses"}, 64'(pulses), 64'(1));
        repeat (2) begin
            tick();
            look();
            chk({tag, "_quiet"}, 64'({mem_en, i_wait, d_wait}), 64'(0));
        end
        chk({tag, "_rd_hold"}, 64'(d_readdata), 64'(v.exp_rd));
    endtask
    initial begin
        int k, last;
        bit seen;
        reset = 1'b1; i_en = 1'b0; d_en = 1'b0; d_wren = 1'b0; mem_wait = 1'b0;
        i_address = '0; d_address = '0; d_writedata = '0; d_byteen = '0; mem_readdata = '0;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 3, 32'h55AA_0FF0, 1'b0, 4'hF, 32'h0, 6};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'h3, 1, 32'hCAFE_F00D, 1'b1, 4'h3, 32'h0, 4};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 4'hF, 32'h1234_5678, 5};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h9999_AAAA, 1'b0, 4'hF, 32'h1234_5678, 3};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_00C0, 32'h0102_0304, 4'hC, 0, 32'hFFFF_FFFF, 1'b1, 4'hC, 32'h1234_5678, 3};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h1, 1, 32'h8765_4321, 1'b0, 4'h1, 32'h8765_4321, 4};
`ifdef MEM_ARB_DPRIO_EN
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        tick();
        tick();
        look();
        chk("reset_ctrl", 64'({mem_en, mem_wren, mem_grant_d, i_wait, d_wait, mem_byteen}), 64'(0));
        chk("reset_addr", 64'(mem_address), 64'(0));
        chk("reset_wdata", 64'(mem_writedata), 64'(0));
        chk("reset_rdata", 64'(d_readdata), 64'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        // Both requesters held: check grant order, 4-cycle pulse spacing, then D drops out.
        do_reset();
        tick();
        mem_lat = 0;
        i_en = 1'b1; i_address = 32'h0000_A000;
        d_en = 1'b1; d_wren = 1'b0; d_address = 32'h0000_B000; d_byteen = 4'hF;
        k = 0;
        last = 0;
        for (int n = 1; n <= 60 && k < 5; n++) begin
            tick();
            look();
            if (mem_en) begin
                chk($sformatf("rr_grant%0d", k), 64'(mem_grant_d), 64'(k < 4 ? exp_order[k] : 1'b0));
                chk($sformatf("rr_addr%0d", k), 64'(mem_address),
                    64'((k < 4 && exp_order[k]) ? 32'h0000_B000 : 32'h0000_A000));
                if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(n - last), 64'(4));
                else chk("rr_first", 64'(n), 64'(1));
                last = n;
                k++;
                if (k == 4) d_en = 1'b0;
            end
        end
        chk("rr_count", 64'(k), 64'(5));
        i_en = 1'b0; d_en = 1'b0;
        // Reset while the bus is in WAIT.
        do_reset();
        tick();
        mem_lat = 5; mem_readdata = 32'hFEED_FACE;
        d_en = 1'b1; d_wren = 1'b0; d_address = 32'h0000_0300; d_byteen = 4'hF;
        tick();
        look();
        chk("rstw_issue", 64'(mem_en), 64'(1));
        tick();
        reset = 1'b1;
        look();
        chk("rstw_in_wait", 64'({mem_en, mem_grant_d, d_wait}), 64'(3'b011));
        tick();
        look();
        chk("rstw_idle", 64'({mem_en, mem_grant_d, i_wait, d_wait}), 64'(4'b0001));
        chk("rstw_rd", 64'(d_readdata), 64'(0));
        chk("rstw_cmd", 64'({mem_wren, mem_byteen, mem_address}), 64'(0));
        tick();
        reset = 1'b0; d_en = 1'b0; rem = 0; mem_wait = 1'b0;
        look();
        chk("rstw_quiet", 64'({mem_en, d_wait}), 64'(0));
        run_vec(vecs[2], "after_rst");
        // D drops en during WAIT while I arrives: D's read still completes, I waits its turn.
        do_reset();
        tick();
        mem_lat = 2; mem_readdata = 32'h0BAD_F00D;
        d_en = 1'b1; d_wren = 1'b0; d_address = 32'h0000_0500; d_byteen = 4'hF;
        tick();
        tick();
        d_en = 1'b0; i_en = 1'b1; i_address = 32'h0000_0600;
        seen = 1'b0;
        for (int n = 3; n <= 20 && !seen; n++) begin
            tick();
            look();
            if (n == 5) begin
                chk("drop_d_rdata", 64'(d_readdata), 64'(32'h0BAD_F00D));
                chk("drop_i_stalled", 64'({i_wait, d_wait}), 64'(2'b10));
            end
            if (mem_en) begin
                chk("drop_i_issue_cycle", 64'(n), 64'(7));
                chk("drop_i_cmd", 64'({mem_grant_d, mem_address}), 64'({1'b0, 32'h0000_0600}));
            end
            if (!i_wait) begin
                seen = 1'b1;
                chk("drop_i_done_cycle", 64'(n), 64'(11));
            end
        end
        chk("drop_i_done_seen", 64'(seen), 64'(1));
        i_en = 1'b0;
        // Randomized traffic against a transaction-level model.
        do_reset();
        begin
            bit m_busy, m_gd, m_last_d, m_wr, done, fin_i, fin_d, pick;
            int m_issue, m_done;
            logic [DW-1:0] m_rd, m_next_rd, m_wd;
            logic [AW-1:0] m_addr;
            logic [BW-1:0] m_be;
            m_busy = 0; m_gd = 0; m_last_d = 0; m_wr = 0; fin_i = 0; fin_d = 0;
            m_issue = 0; m_done = 0; m_rd = '0; m_next_rd = '0; m_wd = '0; m_addr = '0; m_be = '0;
            for (int c = 0; c < 3000; c++) begin
                tick();
                if (fin_i || !i_en) begin
                    i_en = fin_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                    i_address = $urandom;
                end
                if (fin_d || !d_en) begin
                    d_en = fin_d ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                    d_wren = $urandom_range(0, 1) == 1;
                    d_address = $urandom;
                    d_writedata = $urandom;
                    d_byteen = BW'($urandom);
                end
                look();
                done = m_busy && c == m_done;
                if (done && m_gd && !m_wr) m_rd = m_next_rd;
                chk("rnd_cycle", 64'({mem_en, i_wait, d_wait, d_readdata}),
                    64'({m_busy && c == m_issue, i_en && !(done && !m_gd), d_en && !(done && m_gd), m_rd}));
                if (m_busy && c == m_issue) begin
                    chk("rnd_cmd", 64'({mem_grant_d, mem_wren, mem_byteen, mem_address}),
                        64'({m_gd, m_wr, m_be, m_addr}));
                    if (m_gd) chk("rnd_wdata", 64'(mem_writedata), 64'(m_wd));
                end
                fin_i = i_en && done && !m_gd;
                fin_d = d_en && done && m_gd;
                if (done) m_busy = 0;
                else if (!m_busy && (i_en || d_en)) begin
`ifdef MEM_ARB_DPRIO_EN
                    pick = d_en;
`else
                    pick = d_en && (!i_en || !m_last_d);
`endif
                    m_last_d = pick;
                    m_gd = pick;
                    m_busy = 1;
                    m_issue = c + 1;
                    mem_lat = $urandom_range(0, 3);
                    m_done = c + 3 + int'(mem_lat);
                    m_addr = pick ? d_address : i_address;
                    m_wr = pick && d_wren;
                    m_be = pick ? d_byteen : '1;
                    m_wd = d_writedata;
                    m_next_rd = $urandom;
                    mem_readdata = m_next_rd;
                end
            end
        end
        i_en = 1'b0; d_en = 1'b0;
        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
